// File: rtl/sweep_ctrl.sv
// sweep_ctrl: triangle sweep lo->hi->lo with dwell at each extreme, period count and stop/err/done status.
// Optional SWEEP_PRESCALE_EN adds a presc input that slows every step and dwell tick to once per presc+1 cycles.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4,
    parameter int NCYC_W  = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCYC_W-1:0]  ncycles,
`ifdef SWEEP_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, UP, TOP, DOWN, BOT} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   count_n, lo_s, lo_s_n, hi_s, hi_s_n, up_v, dn_v;
    logic [DWELL_W-1:0] dwell_s, dwell_s_n, timer, timer_n;
    logic [NCYC_W-1:0]  ncyc_s, ncyc_s_n, pc, pc_n;
    logic               done_n, err_n, tick, finish;
`ifdef SWEEP_PRESCALE_EN
    logic [PRESC_W-1:0] presc_s, presc_s_n, psc, psc_n;
`endif

    assign dir  = (state == UP) || (state == TOP);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            lo_s    <= '0;
            hi_s    <= '0;
            dwell_s <= '0;
            ncyc_s  <= '0;
            timer   <= '0;
            pc      <= '0;
`ifdef SWEEP_PRESCALE_EN
            presc_s <= '0;
            psc     <= '0;
`endif
        end else begin
            state   <= state_n;
            count   <= count_n;
            done    <= done_n;
            err     <= err_n;
            lo_s    <= lo_s_n;
            hi_s    <= hi_s_n;
            dwell_s <= dwell_s_n;
            ncyc_s  <= ncyc_s_n;
            timer   <= timer_n;
            pc      <= pc_n;
`ifdef SWEEP_PRESCALE_EN
            presc_s <= presc_s_n;
            psc     <= psc_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        done_n    = 1'b0;
        err_n     = err;
        lo_s_n    = lo_s;
        hi_s_n    = hi_s;
        dwell_s_n = dwell_s;
        ncyc_s_n  = ncyc_s;
        timer_n   = timer;
        pc_n      = pc;
        finish    = 1'b0;
        up_v      = count + 1'b1;
        dn_v      = count - 1'b1;
`ifdef SWEEP_PRESCALE_EN
        presc_s_n = presc_s;
        tick      = (psc == presc_s);
        psc_n     = tick ? '0 : psc + 1'b1;
`else
        tick      = 1'b1;
`endif
        case (state)
            IDLE: if (start) begin
                lo_s_n    = lo;
                hi_s_n    = hi;
                dwell_s_n = dwell;
                ncyc_s_n  = ncycles;
`ifdef SWEEP_PRESCALE_EN
                presc_s_n = presc;
                psc_n     = '0;
`endif
                if (lo >= hi) begin
                    err_n = 1'b1;
                end else begin
                    err_n   = 1'b0;
                    count_n = lo;
                    pc_n    = '0;
                    state_n = UP;
                end
            end
            UP: if (tick) begin
                count_n = up_v;
                if (up_v == hi_s) begin
                    state_n = TOP;
                    timer_n = dwell_s;
                end
            end
            TOP: if (tick) begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else begin
                    // a one-step span lands straight on lo, so skip DOWN
                    count_n = hi_s - 1'b1;
                    state_n = (count_n == lo_s) ? BOT : DOWN;
                    timer_n = dwell_s;
                end
            end
            DOWN: if (tick) begin
                count_n = dn_v;
                if (dn_v == lo_s) begin
                    state_n = BOT;
                    timer_n = dwell_s;
                end
            end
            BOT: if (tick) begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else begin
                    pc_n = pc + 1'b1;
                    if (ncyc_s != '0 && pc_n == ncyc_s) begin
                        finish  = 1'b1;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        count_n = lo_s + 1'b1;
                        state_n = (count_n == hi_s) ? TOP : UP;
                        timer_n = dwell_s;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // completion on the same edge outranks an abort
        if (stop && state != IDLE && !finish) begin
            state_n = IDLE;
            count_n = count;
        end
    end
endmodule
